// File: rtl/mem_map_pkg.sv
// Address map shared by the memory system: MMIO register offsets, default
// MMIO base and STATUS register bit positions.
package mem_map_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0000_0800;

    localparam logic [3:0] SIG_OFF  = 4'h0;
    localparam logic [3:0] CON_OFF  = 4'h4;
    localparam logic [3:0] STAT_OFF = 4'h8;
    localparam logic [3:0] CYC_OFF  = 4'hC;

    // Register select is the word index inside the 16-byte MMIO window.
    typedef enum logic [1:0] {
        REG_SIG  = SIG_OFF[3:2],
        REG_CON  = CON_OFF[3:2],
        REG_STAT = STAT_OFF[3:2],
        REG_CYC  = CYC_OFF[3:2]
    } mmio_reg_e;

    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_ERR     = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_CNT_W   = 8;

endpackage

// File: rtl/mem_system_console_fifo.sv
// Console byte FIFO: circular buffer with a sticky overflow flag. A push into
// a full FIFO is still accepted when a pop happens in the same cycle.
module console_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_ovf
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_buf [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW:0]      r_count;
    logic             r_ovf;
    logic             w_pop;
    logic             w_push_ok;

    assign o_empty   = (r_count == '0);
    // Count never exceeds DEPTH (a power of two), so its MSB alone means full.
    assign o_full    = r_count[PW];
    assign w_pop     = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push_ok) r_buf[r_wptr] <= i_push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop)     r_rptr <= r_rptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (i_push && o_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    assign o_head  = o_empty ? '0 : r_buf[r_rptr];
    assign o_count = r_count;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/mem_system.sv
// Unified word RAM plus MMIO window (signature, console FIFO, status, cycle).
// Define CYCLE_COUNTER_EN to implement the free-running CYCLE register.
module mem_system
    import mem_map_pkg::*;
#(
    parameter int          DEPTH      = 1024,
    parameter              INIT_FILE  = "",
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic        sig_valid,
    output logic [31:0] sig_value,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        err_unmapped
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [29:0]   w_word;
    logic [29:0]   w_mmio_off;
    logic          w_mmio_hit;
    logic          w_ram_hit;
    mmio_reg_e     w_reg;
    logic          w_wr_ram;
    logic          w_wr_sig;
    logic          w_wr_con;
    logic          w_wr_unm;
    logic          w_unused_addr;
    logic [31:0]   w_cycle;
    logic [31:0]   w_status;
    logic          w_empty;
    logic          w_full;
    logic          w_ovf;
    logic [CW-1:0] w_count;
    logic [7:0]    w_head;

    logic [31:0]   r_mem [DEPTH];
    logic          r_sig_valid;
    logic [31:0]   r_sig_value;
    logic          r_err;

    // Word-granular decode; MMIO wins if the window overlaps the RAM range.
    assign w_word        = addr[31:2];
    assign w_unused_addr = ^addr[1:0];
    assign w_mmio_off    = w_word - MMIO_BASE[31:2];
    assign w_mmio_hit    = (w_mmio_off < 30'd4);
    assign w_ram_hit     = !w_mmio_hit && (w_word < 30'(DEPTH));
    assign w_reg         = mmio_reg_e'(w_mmio_off[1:0]);

    assign w_wr_ram = we && w_ram_hit;
    assign w_wr_sig = we && w_mmio_hit && (w_reg == REG_SIG);
    assign w_wr_con = we && w_mmio_hit && (w_reg == REG_CON);
    assign w_wr_unm = we && !w_mmio_hit && !w_ram_hit;

    // NOTE: the RAM array has no reset so it maps onto block RAM and keeps
    // its loaded image or earlier writes across a reset.
    always_ff @(posedge clk) begin
        if (w_wr_ram) r_mem[w_word[AW-1:0]] <= wdata;
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sig_valid <= 1'b0;
            r_sig_value <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_wr_sig) begin
                r_sig_valid <= 1'b1;
                r_sig_value <= wdata;
            end
            if (w_wr_unm) r_err <= 1'b1;
        end
    end

`ifdef CYCLE_COUNTER_EN
    logic [31:0] r_cycle;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_cycle <= '0;
        else         r_cycle <= r_cycle + 32'd1;
    end

    assign w_cycle = r_cycle;
`else
    assign w_cycle = '0;
`endif

    console_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_console (
        .clk         (clk),
        .rst_n       (resetn),
        .i_push      (w_wr_con),
        .i_push_data (wdata[7:0]),
        .i_pop       (tx_ready),
        .o_head      (w_head),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_count     (w_count),
        .o_ovf       (w_ovf)
    );

    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_status                                = '0;
        w_status[STAT_EMPTY]                    = w_empty;
        w_status[STAT_FULL]                     = w_full;
        w_status[STAT_ERR]                      = r_err;
        w_status[STAT_OVF]                      = w_ovf;
        w_status[STAT_CNT_LSB +: STAT_CNT_W]    = 8'(w_count);
    end

    // Reads see pre-edge state, so a same-cycle write returns the old value.
    always_comb begin
        rdata = '0;
        if (w_mmio_hit) begin
            case (w_reg)
                REG_SIG:  rdata = r_sig_value;
                REG_CON:  rdata = '0;
                REG_STAT: rdata = w_status;
                REG_CYC:  rdata = w_cycle;
                default:  rdata = '0;
            endcase
        end else if (w_ram_hit) begin
            rdata = r_mem[w_word[AW-1:0]];
        end
    end

    assign sig_valid    = r_sig_valid;
    assign sig_value    = r_sig_value;
    assign err_unmapped = r_err;
    assign tx_valid     = !w_empty;
    assign tx_data      = w_head;

endmodule
